// File: rtl/sprite_draw_controller.sv
// Turns sprite move pulses and clear requests into a serial pixel stream for a
// frame-buffer adapter: erase the old footprint, draw the new one, or wipe the screen.
module sprite_draw_controller #(
    parameter int         SCREEN_W      = 160,
    parameter int         SCREEN_H      = 120,
    parameter int         PLAYER_W      = 3,
    parameter logic [2:0] BG_COLOUR     = 3'b000,
    parameter logic [2:0] PLAYER_COLOUR = 3'b010,
    parameter logic [2:0] ENEMY_COLOUR  = 3'b100,
    parameter logic [2:0] BULLET_COLOUR = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_req,
    input  logic       move_player,
    input  logic [7:0] player_x,
    input  logic [6:0] player_y,
    input  logic       move_enemy,
    input  logic [7:0] enemy_x,
    input  logic [6:0] enemy_y,
    input  logic [2:0] enemy_width,
    input  logic       move_bullet,
    input  logic [7:0] bullet_x,
    input  logic [6:0] bullet_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ERASE = 2'd1;
    localparam logic [1:0] ST_DRAW  = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    localparam logic [1:0] SEL_PL = 2'd0;
    localparam logic [1:0] SEL_EN = 2'd1;
    localparam logic [1:0] SEL_BU = 2'd2;

    localparam logic [2:0] PL_W = 3'(PLAYER_W);

    logic [1:0] state_q, state_d;
    logic       clr_p_q, clr_p_d, pl_p_q, pl_p_d, en_p_q, en_p_d, bu_p_q, bu_p_d;
    logic       pl_v_q, pl_v_d, en_v_q, en_v_d, bu_v_q, bu_v_d;
    logic [7:0] pl_x_q, pl_x_d, en_x_q, en_x_d, bu_x_q, bu_x_d;
    logic [6:0] pl_y_q, pl_y_d, en_y_q, en_y_d, bu_y_q, bu_y_d;
    logic [2:0] en_w_q, en_w_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] snap_x_q, snap_x_d;
    logic [6:0] snap_y_q, snap_y_d;
    logic [2:0] snap_w_q, snap_w_d;
    logic [7:0] dx_q, dx_d;
    logic [6:0] dy_q, dy_d;

    logic [7:0] old_x;
    logic [6:0] old_y;
    logic [2:0] old_w;
    logic [2:0] cur_w_m1;
    logic       last_col, last_row;
    logic       take_clr, take_pl, take_en, take_bu;

    // Footprint of the sprite currently selected, as it was last drawn.
    always_comb begin
        case (sel_q)
            SEL_PL: begin old_x = pl_x_q; old_y = pl_y_q; old_w = PL_W;   end
            SEL_EN: begin old_x = en_x_q; old_y = en_y_q; old_w = en_w_q; end
            default: begin old_x = bu_x_q; old_y = bu_y_q; old_w = 3'd1;  end
        endcase
    end

    assign cur_w_m1 = ((state_q == ST_ERASE) ? old_w : snap_w_q) - 3'd1;
    assign last_col = (dx_q == {5'd0, cur_w_m1});
    assign last_row = (dy_q == {4'd0, cur_w_m1});

    always_comb begin
        state_d  = state_q;
        pl_v_d   = pl_v_q;
        en_v_d   = en_v_q;
        bu_v_d   = bu_v_q;
        pl_x_d   = pl_x_q;
        pl_y_d   = pl_y_q;
        en_x_d   = en_x_q;
        en_y_d   = en_y_q;
        en_w_d   = en_w_q;
        bu_x_d   = bu_x_q;
        bu_y_d   = bu_y_q;
        sel_d    = sel_q;
        snap_x_d = snap_x_q;
        snap_y_d = snap_y_q;
        snap_w_d = snap_w_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        take_clr = 1'b0;
        take_pl  = 1'b0;
        take_en  = 1'b0;
        take_bu  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dx_d = 8'd0;
                dy_d = 7'd0;
                if (clr_p_q) begin
                    take_clr = 1'b1;
                    state_d  = ST_CLEAR;
                end else if (pl_p_q) begin
                    take_pl  = 1'b1;
                    sel_d    = SEL_PL;
                    snap_x_d = player_x;
                    snap_y_d = player_y;
                    snap_w_d = PL_W;
                    state_d  = pl_v_q ? ST_ERASE : ST_DRAW;
                end else if (en_p_q) begin
                    take_en = 1'b1;
                    // A zero-width enemy has no footprint: forget it and stay idle.
                    if (enemy_width == 3'd0) begin
                        en_v_d = 1'b0;
                    end else begin
                        sel_d    = SEL_EN;
                        snap_x_d = enemy_x;
                        snap_y_d = enemy_y;
                        snap_w_d = enemy_width;
                        state_d  = en_v_q ? ST_ERASE : ST_DRAW;
                    end
                end else if (bu_p_q) begin
                    take_bu  = 1'b1;
                    sel_d    = SEL_BU;
                    snap_x_d = bullet_x;
                    snap_y_d = bullet_y;
                    snap_w_d = 3'd1;
                    state_d  = bu_v_q ? ST_ERASE : ST_DRAW;
                end
            end
            ST_ERASE, ST_DRAW: begin
                if (!last_col) begin
                    dx_d = dx_q + 8'd1;
                end else begin
                    dx_d = 8'd0;
                    if (!last_row) begin
                        dy_d = dy_q + 7'd1;
                    end else begin
                        dy_d = 7'd0;
                        if (state_q == ST_ERASE) begin
                            state_d = ST_DRAW;
                        end else begin
                            state_d = ST_IDLE;
                            case (sel_q)
                                SEL_PL: begin
                                    pl_x_d = snap_x_q; pl_y_d = snap_y_q; pl_v_d = 1'b1;
                                end
                                SEL_EN: begin
                                    en_x_d = snap_x_q; en_y_d = snap_y_q;
                                    en_w_d = snap_w_q; en_v_d = 1'b1;
                                end
                                default: begin
                                    bu_x_d = snap_x_q; bu_y_d = snap_y_q; bu_v_d = 1'b1;
                                end
                            endcase
                        end
                    end
                end
            end
            default: begin
                if (dx_q != 8'(SCREEN_W - 1)) begin
                    dx_d = dx_q + 8'd1;
                end else begin
                    dx_d = 8'd0;
                    if (dy_q != 7'(SCREEN_H - 1)) begin
                        dy_d = dy_q + 7'd1;
                    end else begin
                        dy_d    = 7'd0;
                        pl_v_d  = 1'b0;
                        en_v_d  = 1'b0;
                        bu_v_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase

        // A pulse on the same edge as its own service re-arms the request.
        clr_p_d = (clr_p_q & ~take_clr) | clear_req;
        pl_p_d  = (pl_p_q  & ~take_pl)  | move_player;
        en_p_d  = (en_p_q  & ~take_en)  | move_enemy;
        bu_p_d  = (bu_p_q  & ~take_bu)  | move_bullet;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            clr_p_q  <= 1'b0;
            pl_p_q   <= 1'b0;
            en_p_q   <= 1'b0;
            bu_p_q   <= 1'b0;
            pl_v_q   <= 1'b0;
            en_v_q   <= 1'b0;
            bu_v_q   <= 1'b0;
            pl_x_q   <= 8'd0;
            pl_y_q   <= 7'd0;
            en_x_q   <= 8'd0;
            en_y_q   <= 7'd0;
            en_w_q   <= 3'd0;
            bu_x_q   <= 8'd0;
            bu_y_q   <= 7'd0;
            sel_q    <= SEL_PL;
            snap_x_q <= 8'd0;
            snap_y_q <= 7'd0;
            snap_w_q <= 3'd0;
            dx_q     <= 8'd0;
            dy_q     <= 7'd0;
        end else begin
            state_q  <= state_d;
            clr_p_q  <= clr_p_d;
            pl_p_q   <= pl_p_d;
            en_p_q   <= en_p_d;
            bu_p_q   <= bu_p_d;
            pl_v_q   <= pl_v_d;
            en_v_q   <= en_v_d;
            bu_v_q   <= bu_v_d;
            pl_x_q   <= pl_x_d;
            pl_y_q   <= pl_y_d;
            en_x_q   <= en_x_d;
            en_y_q   <= en_y_d;
            en_w_q   <= en_w_d;
            bu_x_q   <= bu_x_d;
            bu_y_q   <= bu_y_d;
            sel_q    <= sel_d;
            snap_x_q <= snap_x_d;
            snap_y_q <= snap_y_d;
            snap_w_q <= snap_w_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
        end
    end

    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] sum_x;
    logic [7:0] sum_y;

    always_comb begin
        base_x = 8'd0;
        base_y = 7'd0;
        colour = 3'b000;
        case (state_q)
            ST_ERASE: begin base_x = old_x; base_y = old_y; colour = BG_COLOUR; end
            ST_DRAW: begin
                base_x = snap_x_q;
                base_y = snap_y_q;
                case (sel_q)
                    SEL_PL:  colour = PLAYER_COLOUR;
                    SEL_EN:  colour = ENEMY_COLOUR;
                    default: colour = BULLET_COLOUR;
                endcase
            end
            ST_CLEAR: colour = BG_COLOUR;
            default: colour = 3'b000;
        endcase
    end

    // Carry out of either sum means the pixel wrapped past the coordinate range.
    assign sum_x = {1'b0, base_x} + {1'b0, dx_q};
    assign sum_y = {1'b0, base_y} + {1'b0, dy_q};
    assign x     = sum_x[7:0];
    assign y     = sum_y[6:0];
    assign busy  = (state_q != ST_IDLE);
    assign plot  = busy && !sum_x[8] && !sum_y[7]
                   && (sum_x[7:0] < 8'(SCREEN_W)) && (sum_y[6:0] < 7'(SCREEN_H));

endmodule

// File: tb/tb_sprite_draw_controller.sv
// Randomised and directed bench for sprite_draw_controller; a job-level model
// expands each serviced request into its expected per-cycle pixel list.
module tb_sprite_draw_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear_req = 1'b0;
    logic       move_player = 1'b0, move_enemy = 1'b0, move_bullet = 1'b0;
    logic [7:0] player_x = 8'd0, enemy_x = 8'd0, bullet_x = 8'd0;
    logic [6:0] player_y = 7'd0, enemy_y = 7'd0, bullet_y = 7'd0;
    logic [2:0] enemy_width = 3'd0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy;

    int total = 0;
    int bad = 0;

    sprite_draw_controller dut (
        .clk(clk), .reset(reset), .clear_req(clear_req),
        .move_player(move_player), .player_x(player_x), .player_y(player_y),
        .move_enemy(move_enemy), .enemy_x(enemy_x), .enemy_y(enemy_y),
        .enemy_width(enemy_width),
        .move_bullet(move_bullet), .bullet_x(bullet_x), .bullet_y(bullet_y),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
        bit p;
    } px_t;

    // ---------------- behavioural model ----------------
    px_t exp_q[$];
    bit  m_pend[4];
    bit  m_valid[3];
    int  m_ox[3], m_oy[3], m_ow[3];
    px_t exp_now;
    bit  exp_busy;

    task automatic push_px(input int bx, input int by, input int c);
        px_t e;
        e.x = bx % 256;
        e.y = by % 128;
        e.c = c;
        e.p = (bx < 160) && (by < 120);
        exp_q.push_back(e);
    endtask

    task automatic push_square(input int bx, input int by, input int w, input int c);
        for (int r = 0; r < w; r++)
            for (int k = 0; k < w; k++)
                push_px(bx + k, by + r, c);
    endtask

    task automatic sprite_job(input int s, input int nx, input int ny, input int nw, input int c);
        if (m_valid[s]) push_square(m_ox[s], m_oy[s], m_ow[s], 0);
        push_square(nx, ny, nw, c);
        m_ox[s] = nx; m_oy[s] = ny; m_ow[s] = nw; m_valid[s] = 1'b1;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_valid[i] = 1'b0; m_ox[i] = 0; m_oy[i] = 0; m_ow[i] = 0;
            end
        end else begin
            bit was_idle;
            was_idle = (exp_q.size() == 0);
            if (!was_idle) void'(exp_q.pop_front());
            else if (m_pend[0]) begin
                m_pend[0] = 1'b0;
                for (int r = 0; r < 120; r++)
                    for (int k = 0; k < 160; k++)
                        push_px(k, r, 0);
                for (int i = 0; i < 3; i++) m_valid[i] = 1'b0;
            end else if (m_pend[1]) begin
                m_pend[1] = 1'b0;
                sprite_job(0, int'(player_x), int'(player_y), 3, 2);
            end else if (m_pend[2]) begin
                m_pend[2] = 1'b0;
                if (enemy_width == 3'd0) m_valid[1] = 1'b0;
                else sprite_job(1, int'(enemy_x), int'(enemy_y), int'(enemy_width), 4);
            end else if (m_pend[3]) begin
                m_pend[3] = 1'b0;
                sprite_job(2, int'(bullet_x), int'(bullet_y), 1, 7);
            end
            if (clear_req)   m_pend[0] = 1'b1;
            if (move_player) m_pend[1] = 1'b1;
            if (move_enemy)  m_pend[2] = 1'b1;
            if (move_bullet) m_pend[3] = 1'b1;
        end
        if (exp_q.size() != 0) begin
            exp_now  = exp_q[0];
            exp_busy = 1'b1;
        end else begin
            exp_now  = '{x: 0, y: 0, c: 0, p: 1'b0};
            exp_busy = 1'b0;
        end
    end

    // ---------------- per-cycle compare and capture ----------------
    px_t cap[$];

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            total++;
            if (int'(x) != exp_now.x || int'(y) != exp_now.y || int'(colour) != exp_now.c
                || plot != exp_now.p || busy != exp_busy) begin
                bad++;
                if (bad < 20)
                    $display("FAIL cycle t=%0t got x=%0d y=%0d c=%0d plot=%0d busy=%0d want x=%0d y=%0d c=%0d plot=%0d busy=%0d",
                             $time, x, y, colour, plot, busy,
                             exp_now.x, exp_now.y, exp_now.c, exp_now.p, exp_busy);
            end
            if (busy) cap.push_back('{x: int'(x), y: int'(y), c: int'(colour), p: plot});
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic chk_px(input string name, input int idx, input int ex, input int ey,
                          input int ec, input int ep);
        total++;
        if (idx >= cap.size()) begin
            bad++;
            $display("FAIL %s missing pixel %0d (captured %0d)", name, idx, cap.size());
        end else if (cap[idx].x != ex || cap[idx].y != ey || cap[idx].c != ec || int'(cap[idx].p) != ep) begin
            bad++;
            $display("FAIL %s got (%0d,%0d,c%0d,p%0d) want (%0d,%0d,c%0d,p%0d)", name,
                     cap[idx].x, cap[idx].y, cap[idx].c, cap[idx].p, ex, ey, ec, ep);
        end
    endtask

    task automatic pulse(input bit cl, input bit pl, input bit en, input bit bu);
        @(negedge clk);
        clear_req = cl; move_player = pl; move_enemy = en; move_bullet = bu;
        @(negedge clk);
        clear_req = 1'b0; move_player = 1'b0; move_enemy = 1'b0; move_bullet = 1'b0;
    endtask

    // Returns once busy has been low for three consecutive samples.
    task automatic wait_idle(input int limit);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < limit) begin
            @(negedge clk);
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        if (quiet < 3) begin
            total++; bad++;
            $display("FAIL wait_idle timeout after %0d cycles", limit);
        end
    endtask

    function automatic int plotted();
        int n = 0;
        foreach (cap[i]) if (cap[i].p) n++;
        return n;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bit clear_used = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_x", int'(x), 0);
        chk("reset_plot", int'(plot), 0);
        chk("reset_busy", int'(busy), 0);

        // First player draw: no erase.
        player_x = 8'd80; player_y = 7'd115;
        cap.delete();
        pulse(0, 1, 0, 0);
        wait_idle(100);
        chk("p1_len", cap.size(), 9);
        chk_px("p1_first", 0, 80, 115, 2, 1);
        chk_px("p1_last", 8, 82, 117, 2, 1);

        // Player move: erase then draw, contiguous.
        player_x = 8'd79;
        cap.delete();
        pulse(0, 1, 0, 0);
        wait_idle(100);
        chk("p2_len", cap.size(), 18);
        chk_px("p2_erase0", 0, 80, 115, 0, 1);
        chk_px("p2_draw0", 9, 79, 115, 2, 1);
        chk_px("p2_last", 17, 81, 117, 2, 1);

        // Enemy at the right edge: x=160 column suppressed.
        enemy_x = 8'd158; enemy_y = 7'd10; enemy_width = 3'd3;
        cap.delete();
        pulse(0, 0, 1, 0);
        wait_idle(100);
        chk("e1_len", cap.size(), 9);
        chk("e1_plotted", plotted(), 6);
        chk_px("e1_offscreen", 2, 160, 10, 4, 0);

        // Simultaneous pulses: player, enemy, bullet in order.
        player_x = 8'd10; player_y = 7'd20;
        enemy_x = 8'd50; enemy_y = 7'd60; enemy_width = 3'd2;
        bullet_x = 8'd5; bullet_y = 7'd5;
        cap.delete();
        pulse(0, 1, 1, 1);
        wait_idle(200);
        chk("multi_len", cap.size(), 18 + 13 + 1);
        chk_px("multi_en_erase", 18, 158, 10, 0, 1);
        chk_px("multi_bullet", 31, 5, 5, 7, 1);

        // Clear requested during a player redraw.
        player_x = 8'd30; player_y = 7'd30;
        cap.delete();
        pulse(0, 1, 0, 0);
        repeat (4) @(negedge clk);
        pulse(1, 0, 0, 0);
        wait_idle(25000);
        chk("clr_len", cap.size(), 18 + 19200);
        chk_px("clr_last", cap.size() - 1, 159, 119, 0, 1);
        bullet_x = 8'd7; bullet_y = 7'd8;
        cap.delete();
        pulse(0, 0, 0, 1);
        wait_idle(100);
        chk("clr_bullet_len", cap.size(), 1);
        chk_px("clr_bullet", 0, 7, 8, 7, 1);

        // Randomised traffic, including overflow coordinates and zero-width enemies.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            player_x = 8'($urandom_range(0, 255)); player_y = 7'($urandom_range(0, 127));
            enemy_x  = 8'($urandom_range(0, 255)); enemy_y  = 7'($urandom_range(0, 127));
            enemy_width = 3'($urandom_range(0, 7));
            bullet_x = 8'($urandom_range(0, 255)); bullet_y = 7'($urandom_range(0, 127));
            move_player = ($urandom_range(0, 15) == 0);
            move_enemy  = ($urandom_range(0, 15) == 0);
            move_bullet = ($urandom_range(0, 9) == 0);
            clear_req   = !clear_used && (i > 1500) && ($urandom_range(0, 199) == 0);
            if (clear_req) clear_used = 1'b1;
        end
        @(negedge clk);
        clear_req = 1'b0; move_player = 1'b0; move_enemy = 1'b0; move_bullet = 1'b0;
        wait_idle(30000);

        // Asynchronous reset in the middle of an erase.
        player_x = 8'd40; player_y = 7'd40;
        pulse(0, 1, 0, 0);
        wait_idle(100);
        pulse(0, 0, 0, 1);
        wait_idle(100);
        player_x = 8'd41;
        pulse(0, 1, 0, 0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_plot", int'(plot), 0);
        chk("arst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_no_pending", int'(busy), 0);
        bullet_x = 8'd3; bullet_y = 7'd3;
        cap.delete();
        pulse(0, 0, 0, 1);
        wait_idle(100);
        chk("arst_bullet_len", cap.size(), 1);
        cap.delete();
        pulse(0, 1, 0, 0);
        wait_idle(100);
        chk("arst_player_len", cap.size(), 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
